// File: rtl/hs_cdc_src_fifo.sv
// Source-side FIFO that feeds a 2-phase handshake CDC. It has first-word fall-through
// output, registered status outputs, and an optional drop-on-full mode with a sticky overflow flag.
package hs_cdc_src_fifo_pkg;
    typedef enum logic {BOOL_FALSE = 1'b0, BOOL_TRUE = 1'b1} bool_e;
endpackage

module hs_cdc_src_fifo
    import hs_cdc_src_fifo_pkg::*;
#(
    parameter type      DATA_TYPE       = logic,
    parameter int       DEPTH           = 4,
    parameter bool_e    DROP_ON_FULL    = BOOL_FALSE,
    parameter bool_e    RESET_DATA_PATH = BOOL_FALSE,
    parameter DATA_TYPE RESET_VALUE     = '0
) (
    input  logic                   src_clk,
    input  logic                   src_aresetn,
    input  DATA_TYPE               in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output DATA_TYPE               out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    input  logic                   overflow_clr
);
    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_overflow;
    DATA_TYPE      r_mem [DEPTH];

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [CW-1:0] w_count_next;

    // Pop is gated by out_valid because the CDC ready pulse ignores src_valid.
    assign w_full = (r_count == FULL_COUNT);
    assign w_push = in_valid && r_in_ready && !w_full;
    assign w_pop  = r_out_valid && out_ready;
    assign w_drop = (DROP_ON_FULL == BOOL_TRUE) && in_valid && w_full;

    always_comb begin
        // NOTE: assign the default first. Every path then drives w_count_next, so no latch is inferred.
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge src_clk or negedge src_aresetn) begin
        if (!src_aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments here. Every register then samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != '0);
            r_in_ready  <= (DROP_ON_FULL == BOOL_TRUE) || (w_count_next != FULL_COUNT);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is reset only when asked for. Otherwise it maps onto plain RAM/flops with no reset.
    generate
        if (RESET_DATA_PATH == BOOL_TRUE) begin : g_mem_rst
            always_ff @(posedge src_clk or negedge src_aresetn) begin
                if (!src_aresetn) begin
                    for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VALUE;
                end else if (w_push) begin
                    r_mem[r_wr_ptr] <= in_data;
                end
            end
        end else begin : g_mem_norst
            always_ff @(posedge src_clk) begin
                if (w_push) r_mem[r_wr_ptr] <= in_data;
            end
        end
    endgenerate

    // Head entry stays put until popped. Writes never target rd_ptr while entries are queued.
    assign out_data   = r_mem[r_rd_ptr];
    assign out_valid  = r_out_valid;
    assign in_ready   = r_in_ready;
    assign fill_level = r_count;
    assign overflow   = r_overflow;

endmodule
